vt_esc_decoder: RTL and testbench

- Sits between the serial receiver and the character-cell writer state machine.
- Consumes the receiver's one-cycle byte strobe and separates printable and control bytes from ANSI CSI sequences.
- Emits a single command stream with ready/valid handshake: CHAR, cursor position (CUP), erase display (ED) and erase line (EL).
- Shields the writer from escape bytes, which would otherwise be drawn as glyphs.

---
 rtl/vt_pkg.sv | 46 ++++
 rtl/vt_csi_param.sv | 45 ++++
 rtl/vt_esc_decoder.sv | 172 +++++++++++++++++
 tb/tb_vt_esc_decoder.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vt_pkg.sv
// Shared encodings for the VT escape decoder: command kinds, byte constants,
// FSM states and default screen geometry.
package vt_pkg;

    localparam int ROWS_DEF = 25;
    localparam int COLS_DEF = 80;

    typedef enum logic [1:0] {
        KIND_CHAR = 2'd0,
        KIND_CUP  = 2'd1,
        KIND_ED   = 2'd2,
        KIND_EL   = 2'd3
    } kind_t;

    typedef enum logic [1:0] {
        ST_GROUND = 2'd0,
        ST_ESC    = 2'd1,
        ST_CSI    = 2'd2
    } state_t;

    localparam logic [7:0] ESC      = 8'h1B;
    localparam logic [7:0] LBRACKET = 8'h5B;
    localparam logic [7:0] SEMI     = 8'h3B;
    localparam logic [7:0] CR       = 8'h0D;
    localparam logic [7:0] LF       = 8'h0A;
    localparam logic [7:0] FF       = 8'h0C;
    localparam logic [7:0] BS       = 8'h08;

    // Bytes the writer draws or interprets itself; everything else is noise.
    function automatic logic is_glyph(input logic [7:0] b);
        return (b == BS) || (b == LF) || (b == FF) || (b == CR) ||
               (b >= 8'h20 && b <= 8'h7E) || b[7];
    endfunction

    // 1-based parameter (0 meaning 1) to 0-based coordinate, clipped to lim-1.
    function automatic logic [7:0] clip_coord(input logic [7:0] p,
                                              input int lim);
        logic [7:0] v;
        v = (p == 8'd0) ? 8'd0 : p - 8'd1;
        if (int'(v) > lim - 1) begin
            v = 8'(lim - 1);
        end
        return v;
    endfunction

endpackage

// File: rtl/vt_csi_param.sv
// Decimal accumulator for the two CSI parameters, saturating at 255,
// with a ';'-driven index that stops at 2.
module vt_csi_param
    import vt_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       digit,
    input  logic [3:0] value,
    input  logic       semi,
    output logic [7:0] p0,
    output logic [7:0] p1
);

    logic [1:0]  idx;
    logic [11:0] acc_in;
    logic [11:0] acc;
    logic [7:0]  sat;

    always_comb begin
        acc_in = (idx == 2'd0) ? {4'd0, p0} : {4'd0, p1};
        acc    = acc_in * 12'd10 + {8'd0, value};
        sat    = (acc > 12'd255) ? 8'hFF : acc[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            p0  <= 8'd0;
            p1  <= 8'd0;
            idx <= 2'd0;
        end else begin
            if (digit && idx == 2'd0) begin
                p0 <= sat;
            end
            if (digit && idx == 2'd1) begin
                p1 <= sat;
            end
            if (semi && idx != 2'd2) begin
                idx <= idx + 2'd1;
            end
        end
    end

endmodule

// File: rtl/vt_esc_decoder.sv
// Byte-stream to command-stream decoder (CHAR/CUP/ED/EL) for the text writer.
// Optional abandon-on-idle timeout for partial sequences: VT_ESC_TIMEOUT_EN.
module vt_esc_decoder
    import vt_pkg::*;
#(
    parameter int ROWS           = ROWS_DEF,
    parameter int COLS           = COLS_DEF,
    parameter int TIMEOUT_CYCLES = 25000
) (
    input  logic       clk25,
    input  logic       rst,
    input  logic       serwr,
    input  logic [7:0] serdata,
    output logic       out_valid,
    input  logic       out_rdy,
    output logic [1:0] out_kind,
    output logic [7:0] out_char,
    output logic [4:0] out_row,
    output logic [6:0] out_col,
    output logic       ovf
);

    state_t     state;
    state_t     next_state;
    logic       hold_full;
    logic [7:0] hold_byte;
    logic       consume;
    logic       timeout;

    logic       is_digit;
    logic       is_final;
    logic [7:0] p0;
    logic [7:0] p1;

    logic       emit;
    kind_t      kind_n;
    logic [7:0] char_n;
    logic [4:0] row_n;
    logic [6:0] col_n;

    // The FSM only takes a byte when its result has somewhere to go.
    assign consume  = hold_full && (!out_valid || out_rdy);
    assign is_digit = (hold_byte >= 8'h30) && (hold_byte <= 8'h39);
    assign is_final = (hold_byte >= 8'h40) && (hold_byte <= 8'h7E);

    vt_csi_param u_param (
        .clk   (clk25),
        .rst   (rst),
        .clear (consume && state == ST_ESC && hold_byte == LBRACKET),
        .digit (consume && state == ST_CSI && is_digit),
        .value (hold_byte[3:0]),
        .semi  (consume && state == ST_CSI && hold_byte == SEMI),
        .p0    (p0),
        .p1    (p1)
    );

    always_comb begin
        next_state = state;
        emit       = 1'b0;
        kind_n     = KIND_CHAR;
        char_n     = 8'd0;
        row_n      = 5'd0;
        col_n      = 7'd0;
        if (consume) begin
            unique case (state)
                ST_GROUND: begin
                    if (hold_byte == ESC) begin
                        next_state = ST_ESC;
                    end else if (is_glyph(hold_byte)) begin
                        emit   = 1'b1;
                        char_n = hold_byte;
                    end
                end
                ST_ESC: begin
                    if (hold_byte == LBRACKET) begin
                        next_state = ST_CSI;
                    end else if (hold_byte != ESC) begin
                        next_state = ST_GROUND;
                    end
                end
                ST_CSI: begin
                    unique case (1'b1)
                        hold_byte == ESC: next_state = ST_ESC;
                        is_final: begin
                            next_state = ST_GROUND;
                            unique case (1'b1)
                                hold_byte == 8'h48,
                                hold_byte == 8'h66: begin
                                    emit   = 1'b1;
                                    kind_n = KIND_CUP;
                                    row_n  = 5'(clip_coord(p0, ROWS));
                                    col_n  = 7'(clip_coord(p1, COLS));
                                end
                                hold_byte == 8'h4A: begin
                                    emit   = (p0 == 8'd2);
                                    kind_n = KIND_ED;
                                end
                                hold_byte == 8'h4B: begin
                                    emit   = (p0 == 8'd0);
                                    kind_n = KIND_EL;
                                end
                                default: ;
                            endcase
                        end
                        default: ;
                    endcase
                end
                default: next_state = ST_GROUND;
            endcase
        end
    end

`ifdef VT_ESC_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle_cnt;

    // A byte taken on the same edge keeps the sequence alive.
    assign timeout = (state != ST_GROUND) && !consume &&
                     (int'(idle_cnt) == TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk25) begin
        if (rst || consume || state == ST_GROUND || timeout) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk25) begin
        if (rst) begin
            state     <= ST_GROUND;
            hold_full <= 1'b0;
            hold_byte <= 8'd0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            out_kind  <= KIND_CHAR;
            out_char  <= 8'd0;
            out_row   <= 5'd0;
            out_col   <= 7'd0;
        end else begin
            if (serwr && (!hold_full || consume)) begin
                hold_full <= 1'b1;
                hold_byte <= serdata;
            end else if (consume) begin
                hold_full <= 1'b0;
            end
            if (serwr && hold_full && !consume) begin
                ovf <= 1'b1;
            end
            state <= timeout ? ST_GROUND : next_state;
            if (emit) begin
                out_valid <= 1'b1;
                out_kind  <= kind_n;
                out_char  <= char_n;
                out_row   <= row_n;
                out_col   <= col_n;
            end else if (out_valid && out_rdy) begin
                out_valid <= 1'b0;
                out_kind  <= KIND_CHAR;
                out_char  <= 8'd0;
                out_row   <= 5'd0;
                out_col   <= 7'd0;
            end
        end
    end

endmodule

// File: tb/tb_vt_esc_decoder.sv
// Directed and randomized checks of vt_esc_decoder against a byte-level
// model of the escape grammar.
module tb_vt_esc_decoder;

    localparam int ROWS = 25;
    localparam int COLS = 80;

    logic       clk25 = 1'b0;
    logic       rst;
    logic       serwr;
    logic [7:0] serdata;
    logic       out_valid;
    logic       out_rdy;
    logic [1:0] out_kind;
    logic [7:0] out_char;
    logic [4:0] out_row;
    logic [6:0] out_col;
    logic       ovf;

    int n_cmp = 0;
    int n_bad = 0;

    logic [21:0] got_q[$];
    logic [21:0] exp_q[$];

    int m_st;
    int m_p[2];
    int m_i;

    always #5 clk25 = ~clk25;

    vt_esc_decoder #(
        .ROWS           (ROWS),
        .COLS           (COLS),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk25     (clk25),
        .rst       (rst),
        .serwr     (serwr),
        .serdata   (serdata),
        .out_valid (out_valid),
        .out_rdy   (out_rdy),
        .out_kind  (out_kind),
        .out_char  (out_char),
        .out_row   (out_row),
        .out_col   (out_col),
        .ovf       (ovf)
    );

    always @(negedge clk25) begin
        if (!rst && out_valid && out_rdy) begin
            got_q.push_back({out_kind, out_char, out_row, out_col});
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [21:0] cmd(input int k, input int ch,
                                        input int r, input int c);
        return {2'(k), 8'(ch), 5'(r), 7'(c)};
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic step();
        @(posedge clk25);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        serwr   = 1'b1;
        serdata = b;
        step();
        serwr   = 1'b0;
        step();
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send(s[i]);
        end
    endtask

    task automatic expect_cmd(input string tag, input logic [21:0] e);
        int w;
        w = 0;
        while (got_q.size() == 0 && w < 30) begin
            step();
            w++;
        end
        if (got_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL %s observed=no-command expected=%h", tag, e);
        end else begin
            check(tag, 32'(got_q.pop_front()), 32'(e));
        end
    endtask

    task automatic expect_none(input string tag);
        repeat (10) step();
        check(tag, got_q.size(), 0);
        got_q.delete();
    endtask

    // Reference grammar, one byte at a time.
    task automatic model_byte(input int b);
        case (m_st)
            0: begin
                if (b == 27) begin
                    m_st = 1;
                end else if (b == 8 || b == 10 || b == 12 || b == 13 ||
                             (b >= 32 && b <= 126) || b >= 128) begin
                    exp_q.push_back(cmd(0, b, 0, 0));
                end
            end
            1: begin
                if (b == 91) begin
                    m_st   = 2;
                    m_p[0] = 0;
                    m_p[1] = 0;
                    m_i    = 0;
                end else if (b != 27) begin
                    m_st = 0;
                end
            end
            default: begin
                if (b >= 48 && b <= 57) begin
                    if (m_i < 2) m_p[m_i] = imin(m_p[m_i] * 10 + b - 48, 255);
                end else if (b == 59) begin
                    if (m_i < 2) m_i++;
                end else if (b == 27) begin
                    m_st = 1;
                end else if (b >= 64 && b <= 126) begin
                    m_st = 0;
                    if (b == 72 || b == 102) begin
                        exp_q.push_back(cmd(1, 0,
                            imin(imax(m_p[0], 1) - 1, ROWS - 1),
                            imin(imax(m_p[1], 1) - 1, COLS - 1)));
                    end else if (b == 74 && m_p[0] == 2) begin
                        exp_q.push_back(cmd(2, 0, 0, 0));
                    end else if (b == 75 && m_p[0] == 0) begin
                        exp_q.push_back(cmd(3, 0, 0, 0));
                    end
                end
            end
        endcase
    endtask

    function automatic logic [7:0] pick_byte();
        string fin;
        fin = "HfJKm";
        case ($urandom_range(0, 9))
            0:       return 8'h1B;
            1, 9:    return 8'h5B;
            2, 3:    return 8'(8'h30 + $urandom_range(0, 9));
            4:       return 8'h3B;
            5:       return fin[$urandom_range(0, 4)];
            6:       return 8'($urandom_range(0, 255));
            7:       return 8'($urandom_range(8'h20, 8'h7E));
            default: return ($urandom_range(0, 1) == 0) ? 8'h30 : 8'h32;
        endcase
    endfunction

    initial begin
        logic [7:0] b;
        int w;
        rst     = 1'b1;
        serwr   = 1'b0;
        serdata = 8'd0;
        out_rdy = 1'b1;
        repeat (3) step();
        check("rst_valid", out_valid, 0);
        check("rst_kind", out_kind, 0);
        check("rst_char", out_char, 0);
        check("rst_row", out_row, 0);
        check("rst_col", out_col, 0);
        check("rst_ovf", ovf, 0);
        rst = 1'b0;
        step();

        // Latency: strobe at edge k, out_valid after edge k+1.
        serwr   = 1'b1;
        serdata = 8'h41;
        step();
        serwr = 1'b0;
        check("lat_k", out_valid, 0);
        step();
        check("lat_k1", out_valid, 1);
        check("lat_char", out_char, 8'h41);
        expect_cmd("char_A", cmd(0, 8'h41, 0, 0));
        send(8'h0D);
        expect_cmd("char_CR", cmd(0, 8'h0D, 0, 0));
        send(8'h0A);
        expect_cmd("char_LF", cmd(0, 8'h0A, 0, 0));
        send(8'h07);
        send(8'h7F);
        expect_none("bel_del");

        send(8'h1B); send_str("[12;40H");
        expect_cmd("cup_12_40", cmd(1, 0, 11, 39));
        send(8'h1B); send_str("[99;200H");
        expect_cmd("cup_clip", cmd(1, 0, 24, 79));
        send(8'h1B); send_str("[H");
        expect_cmd("cup_home", cmd(1, 0, 0, 0));
        send(8'h1B); send_str("[2J");
        expect_cmd("ed_2", cmd(2, 0, 0, 0));
        send(8'h1B); send_str("[1J");
        expect_none("ed_1");
        send(8'h1B); send_str("[K");
        expect_cmd("el_0", cmd(3, 0, 0, 0));
        send(8'h1B); send_str("[5m");
        expect_none("sgr");
        send(8'h1B); send_str("[300;1H");
        expect_cmd("cup_sat", cmd(1, 0, 24, 0));
        expect_none("after_sat");

        // Backpressure: X pending, Y held, Z dropped.
        out_rdy = 1'b0;
        send(8'h58);
        send(8'h59);
        send(8'h5A);
        check("bp_ovf", ovf, 1);
        check("bp_valid", out_valid, 1);
        check("bp_char", out_char, 8'h58);
        check("bp_none", got_q.size(), 0);
        out_rdy = 1'b1;
        expect_cmd("bp_X", cmd(0, 8'h58, 0, 0));
        expect_cmd("bp_Y", cmd(0, 8'h59, 0, 0));
        expect_none("bp_Z_dropped");
        check("bp_ovf_sticky", ovf, 1);

        send(8'h1B); send_str("[3");
        send(8'h1B); send_str("[1;1H");
        expect_cmd("esc_restart", cmd(1, 0, 0, 0));
        expect_none("esc_restart_only");

        send(8'h1B); send_str("[1");
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst2_ovf", ovf, 0);
        check("rst2_valid", out_valid, 0);
        send(8'h48);
        expect_cmd("rst_mid_seq", cmd(0, 8'h48, 0, 0));

        send(8'h1B); send_str("[");
        repeat (110) step();
        send(8'h48);
`ifdef VT_ESC_TIMEOUT_EN
        expect_cmd("timeout_H", cmd(0, 8'h48, 0, 0));
`else
        expect_cmd("no_timeout_H", cmd(1, 0, 0, 0));
`endif
        expect_none("after_timeout");

        // Random bytes with random backpressure against the model.
        m_st = 0;
        m_p[0] = 0;
        m_p[1] = 0;
        m_i = 0;
        exp_q.delete();
        got_q.delete();
        for (int n = 0; n < 400; n++) begin
            w = 0;
            while (out_valid && w < 60) begin
                out_rdy = 1'($urandom_range(0, 1));
                step();
                w++;
            end
            if (out_valid) begin
                n_cmp++;
                n_bad++;
                $error("FAIL rnd_drain observed=stuck expected=drained");
            end
            b = pick_byte();
            model_byte(int'(b));
            out_rdy = 1'($urandom_range(0, 1));
            send(b);
        end
        out_rdy = 1'b1;
        repeat (10) step();
        check("rnd_count", got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            check("rnd_cmd", 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
        end
        check("rnd_ovf", ovf, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
